// File: rtl/pcpu_run_harness.sv
// pcpu_run_harness: program/data memory and run controller for pcpu.
// Host loads, starts a run, harness serves the core and reports stats.
module pcpu_run_harness #(
  parameter int DATA_W = 16,
  parameter int IADDR_W = 8,
  parameter int DADDR_W = 8,
  parameter int OP_W = 5,
  parameter logic [OP_W-1:0] HALT_OP = 5'b00001,
  parameter int DRAIN_CYC = 4,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 1024,
  localparam int LD_AW = (IADDR_W > DADDR_W) ? IADDR_W : DADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_sel,
  input  logic [LD_AW-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              run_req,
  input  logic [DADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_enable,
  output logic              cpu_start,
  input  logic [IADDR_W-1:0] cpu_iAddr,
  output logic [DATA_W-1:0] cpu_iDataIn,
  input  logic [DADDR_W-1:0] cpu_dAddr,
  input  logic [DATA_W-1:0] cpu_dDataOut,
  input  logic              cpu_dWE,
  output logic [DATA_W-1:0] cpu_dDataIn,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  store_count
);

  localparam int DC_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [DC_W-1:0] DC_INIT = DC_W'(DRAIN_CYC);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit HAS_DRAIN = (DRAIN_CYC != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  logic [DC_W-1:0] drain_cnt;

  logic [DATA_W-1:0] imem [2**IADDR_W];
  logic [DATA_W-1:0] dmem [2**DADDR_W];

  logic ld_ok;
  logic store_en;
  logic halt_hit;
  logic to_hit;
  logic cyc_sat;
  logic st_sat;
  logic launch;
  logic drain_last;

  assign ld_ready = ~busy;
  assign ld_ok = ld_valid & ld_ready;
  assign store_en = busy & cpu_dWE;
  assign launch = run_req & ~busy;

  assign cpu_iDataIn = imem[cpu_iAddr];
  assign cpu_dDataIn = dmem[cpu_dAddr];

  assign halt_hit = (cpu_iDataIn[DATA_W-1 -: OP_W] == HALT_OP);
  assign to_hit = (cycle_count == TO_LAST);
  assign cyc_sat = &cycle_count;
  assign st_sat = &store_count;
  assign drain_last = (drain_cnt <= DC_W'(1));

  // Run controller: state, registered handshake outputs and cycle counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      drain_cnt <= '0;
      cpu_enable <= 1'b0;
      cpu_start <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      timed_out <= 1'b0;
      cycle_count <= '0;
    end else begin
      cpu_start <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (run_req) begin
            state <= S_START;
            cpu_start <= 1'b1;
            cpu_enable <= 1'b1;
            busy <= 1'b1;
            done <= 1'b0;
            timed_out <= 1'b0;
            cycle_count <= '0;
          end
        end
        S_START: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (!cyc_sat) cycle_count <= cycle_count + 1'b1;
          if (halt_hit && HAS_DRAIN) begin
            state <= S_DRAIN;
            drain_cnt <= DC_INIT;
          end else if (halt_hit || to_hit) begin
            state <= S_DONE;
            cpu_enable <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
            timed_out <= ~halt_hit;
          end
        end
        S_DRAIN: begin
          if (!cyc_sat) cycle_count <= cycle_count + 1'b1;
          if (drain_last) begin
            state <= S_DONE;
            cpu_enable <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Store counter: cleared on launch, saturates at all-ones
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      store_count <= '0;
    end else if (launch) begin
      store_count <= '0;
    end else if (store_en && !st_sat) begin
      store_count <= store_count + 1'b1;
    end
  end

  // Instruction memory: host loads only
  always_ff @(posedge clock) begin
    if (ld_ok && !ld_sel) imem[ld_addr[IADDR_W-1:0]] <= ld_data;
  end

  // Data memory: host loads when idle, core stores while busy
  always_ff @(posedge clock) begin
    if (ld_ok && ld_sel) begin
      dmem[ld_addr[DADDR_W-1:0]] <= ld_data;
    end else if (store_en) begin
      dmem[cpu_dAddr] <= cpu_dDataOut;
    end
  end

  // Host read port, one cycle latency
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_data <= '0;
    else rd_data <= dmem[rd_addr];
  end

endmodule

// File: tb/tb_pcpu_run_harness.sv
// tb_pcpu_run_harness: bench plays host and core against a memory model.
// Expected run length comes from scanning the program for the first HALT.
module tb_pcpu_run_harness;

  localparam int TO = 40;
  localparam int DC = 4;

  logic clock = 1'b0;
  logic reset;
  logic ld_valid;
  logic ld_ready;
  logic ld_sel;
  logic [7:0] ld_addr;
  logic [15:0] ld_data;
  logic run_req;
  logic [7:0] rd_addr;
  logic [15:0] rd_data;
  logic cpu_enable;
  logic cpu_start;
  logic [7:0] cpu_iAddr;
  logic [15:0] cpu_iDataIn;
  logic [7:0] cpu_dAddr;
  logic [15:0] cpu_dDataOut;
  logic cpu_dWE;
  logic [15:0] cpu_dDataIn;
  logic busy;
  logic done;
  logic timed_out;
  logic [15:0] cycle_count;
  logic [15:0] store_count;

  logic [15:0] im_m [256];
  logic [15:0] dm_m [256];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pcpu_run_harness #(
    .TIMEOUT(TO),
    .DRAIN_CYC(DC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_sel(ld_sel),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .run_req(run_req),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .cpu_enable(cpu_enable),
    .cpu_start(cpu_start),
    .cpu_iAddr(cpu_iAddr),
    .cpu_iDataIn(cpu_iDataIn),
    .cpu_dAddr(cpu_dAddr),
    .cpu_dDataOut(cpu_dDataOut),
    .cpu_dWE(cpu_dWE),
    .cpu_dDataIn(cpu_dDataIn),
    .busy(busy),
    .done(done),
    .timed_out(timed_out),
    .cycle_count(cycle_count),
    .store_count(store_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] nonhalt();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:11] == 5'b00001) w[15] = 1'b1;
    return w;
  endfunction

  function automatic logic [15:0] haltw();
    return {5'b00001, 11'($urandom)};
  endfunction

  task automatic load(input bit sel, input int a, input logic [15:0] d);
    ld_valid = 1'b1;
    ld_sel = sel;
    ld_addr = 8'(a);
    ld_data = d;
    #1;
    chk("ld_ready_idle", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 1'b0;
    if (sel) dm_m[a & 255] = d;
    else im_m[a & 255] = d;
  endtask

  task automatic readback();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 8'(a);
      step();
      chk("rd_data", 32'(rd_data), 32'(dm_m[a]));
    end
  endtask

  task automatic run(input int p0, input bit poke_ld, input bit poke_req,
                     input bit co_ld, input int co_a,
                     input logic [15:0] co_d);
    int cc;
    bit to;
    int sc;
    int pa;
    sc = 0;
    to = 1'b1;
    cc = TO;
    for (int k = 1; k <= TO; k++) begin
      if (im_m[(p0 + k - 1) & 255][15:11] == 5'b00001) begin
        cc = k + DC;
        to = 1'b0;
        break;
      end
    end
    run_req = 1'b1;
    if (co_ld) begin
      ld_valid = 1'b1;
      ld_sel = 1'b1;
      ld_addr = 8'(co_a);
      ld_data = co_d;
      dm_m[co_a & 255] = co_d;
    end
    step();
    run_req = 1'b0;
    ld_valid = 1'b0;
    chk("start_pulse", 32'(cpu_start), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ld_ready", 32'(ld_ready), 32'd0);
    chk("start_done", 32'(done), 32'd0);
    chk("start_cyc", 32'(cycle_count), 32'd0);
    chk("start_st", 32'(store_count), 32'd0);
    for (int j = 0; j <= cc + 3; j++) begin
      cpu_iAddr = 8'(p0 + ((j > 0) ? j - 1 : 0));
      cpu_dWE = ($urandom_range(2) == 0);
      cpu_dAddr = 8'($urandom_range(15));
      cpu_dDataOut = 16'($urandom);
      pa = 5;
      if (poke_ld && j == 2) begin
        ld_valid = 1'b1;
        ld_sel = 1'b1;
        ld_addr = 8'(pa);
        ld_data = ~dm_m[pa];
      end
      if (poke_req && !to && j == cc - 1) run_req = 1'b1;
      #1;
      chk("enable", 32'(cpu_enable), 32'(j <= cc));
      chk("busy", 32'(busy), 32'(j <= cc));
      chk("done", 32'(done), 32'(j > cc));
      chk("fetch", 32'(cpu_iDataIn), 32'(im_m[cpu_iAddr]));
      if (j == 1) chk("start_drop", 32'(cpu_start), 32'd0);
      if (poke_ld && j == 2) chk("ld_ready_run", 32'(ld_ready), 32'd0);
      if (cpu_dWE && j <= cc) begin
        chk("rdw_old", 32'(cpu_dDataIn), 32'(dm_m[cpu_dAddr]));
        dm_m[cpu_dAddr] = cpu_dDataOut;
        sc++;
      end
      step();
      ld_valid = 1'b0;
      run_req = 1'b0;
    end
    cpu_dWE = 1'b0;
    chk("end_done", 32'(done), 32'd1);
    chk("end_timeout", 32'(timed_out), 32'(to));
    chk("end_cyc", 32'(cycle_count), 32'(cc));
    chk("end_st", 32'(store_count), 32'(sc));
    chk("end_ld_ready", 32'(ld_ready), 32'd1);
    readback();
  endtask

  initial begin
    reset = 1'b1;
    ld_valid = 1'b0;
    ld_sel = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    run_req = 1'b0;
    rd_addr = '0;
    cpu_iAddr = '0;
    cpu_dAddr = '0;
    cpu_dDataOut = '0;
    cpu_dWE = 1'b0;
    #3;
    chk("rst_enable", 32'(cpu_enable), 32'd0);
    chk("rst_start", 32'(cpu_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_to", 32'(timed_out), 32'd0);
    chk("rst_cyc", 32'(cycle_count), 32'd0);
    chk("rst_st", 32'(store_count), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    step();

    for (int a = 0; a < 16; a++) load(1'b1, a, 16'($urandom));
    for (int a = 0; a < 256; a++) load(1'b0, a, nonhalt());
    load(1'b0, 20, haltw());
    load(1'b0, 189, haltw());
    load(1'b0, 200, haltw());

    // halt after 21 fetches
    run(0, 1'b0, 1'b0, 1'b0, 0, 16'h0);
    // no halt in window: timeout, with a stalled host load
    run(100, 1'b1, 1'b0, 1'b0, 0, 16'h0);
    // load accepted once done
    load(1'b1, 7, 16'hBEEF);
    // halt on the very last allowed fetch, run_req during drain
    run(150, 1'b0, 1'b1, 1'b0, 0, 16'h0);

    // reset in the middle of a run
    run_req = 1'b1;
    step();
    run_req = 1'b0;
    for (int j = 0; j < 6; j++) begin
      cpu_iAddr = 8'((j > 0) ? j - 1 : 0);
      cpu_dWE = 1'b1;
      cpu_dAddr = 8'($urandom_range(15));
      cpu_dDataOut = 16'($urandom);
      dm_m[cpu_dAddr] = cpu_dDataOut;
      step();
    end
    cpu_dWE = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_enable", 32'(cpu_enable), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("mid_rst_cyc", 32'(cycle_count), 32'd0);
    chk("mid_rst_st", 32'(store_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();
    readback();

    // reload and run, with a load arriving alongside run_req
    load(1'b0, 200, haltw());
    run(200, 1'b0, 1'b0, 1'b1, 9, 16'h5A5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
